// File: rtl/or_div_8x4_if.sv
// Request/result bundle for the 8/4 restoring divider.
// The master drives start and the operands; the slave (the divider) returns status and results.
interface or_div_8x4_if;
    logic       start;
    logic [7:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] Y;
    logic [3:0] R;
    logic       div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, Y, R, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, Y, R, div_by_zero
    );
endinterface

// File: rtl/or_div_8x4.sv
// Iterative radix-2 restoring divider, 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Optional macro OR_DIV_REM_EN: when defined, R carries the remainder; otherwise R is tied to zero.
//
// state | meaning
// IDLE  | waiting for start; completes divide-by-zero requests in place
// RUN   | shifting in dividend bits, MSB first, one quotient bit per cycle
module or_div_8x4 (
    input  logic           clk,
    input  logic           rst_n,
    or_div_8x4_if.slave    div_if
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [4:0] p_q, p_d;
    logic [7:0] q_q, q_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] y_q, y_d;
    logic       dbz_q, dbz_d;
    logic       done_q, done_d;
`ifdef OR_DIV_REM_EN
    logic [3:0] r_q, r_d;
`endif

    logic [4:0] p_shift;
    logic [4:0] p_sub;
    logic       fits;

    // P stays below b_lat after each step, so the shifted value always fits in 5 bits.
    always_comb begin
        p_shift = {p_q[3:0], a_q[cnt_q]};
        fits    = (p_shift >= {1'b0, b_q});
        p_sub   = p_shift - {1'b0, b_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
`ifdef OR_DIV_REM_EN
        r_d     = r_q;
`endif
        case (state_q)
            IDLE: begin
                if (div_if.start) begin
                    a_d   = div_if.a;
                    b_d   = div_if.b;
                    p_d   = 5'd0;
                    q_d   = 8'd0;
                    cnt_d = 3'd0;
                    if (div_if.b == 4'd0) begin
                        y_d    = 8'hFF;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
`ifdef OR_DIV_REM_EN
                        r_d    = 4'hF;
`endif
                    end else begin
                        state_d = RUN;
                        cnt_d   = 3'd7;
                    end
                end
            end
            RUN: begin
                if (fits) begin
                    p_d        = p_sub;
                    q_d[cnt_q] = 1'b1;
                end else begin
                    p_d        = p_shift;
                    q_d[cnt_q] = 1'b0;
                end
                if (cnt_q == 3'd0) begin
                    y_d     = q_d;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef OR_DIV_REM_EN
                    r_d     = p_d[3:0];
`endif
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 8'd0;
            b_q     <= 4'd0;
            p_q     <= 5'd0;
            q_q     <= 8'd0;
            cnt_q   <= 3'd0;
            y_q     <= 8'd0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

`ifdef OR_DIV_REM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 4'd0;
        end else begin
            r_q <= r_d;
        end
    end

    assign div_if.R = r_q;
`else
    assign div_if.R = 4'h0;
`endif

    assign div_if.busy        = (state_q == RUN);
    assign div_if.done        = done_q;
    assign div_if.Y           = y_q;
    assign div_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_or_div_8x4.sv
// Self-checking bench for or_div_8x4: directed cases, reset abort, back-to-back and a shuffled full sweep
// with operand toggling during RUN, checked against plain integer division.
module tb_or_div_8x4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    or_div_8x4_if div_if();

    or_div_8x4 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_if (div_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_y(input int av, input int bv);
        return (bv == 0) ? 8'hFF : 8'(av / bv);
    endfunction

    function automatic logic [3:0] ref_r(input int av, input int bv);
`ifdef OR_DIV_REM_EN
        return (bv == 0) ? 4'hF : 4'(av % bv);
`else
        return 4'h0;
`endif
    endfunction

    // Waits (bounded) for done, sampled 1 time unit after each rising edge.
    task automatic wait_done(input bit toggle, output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (div_if.done !== 1'b1 && lat < 20) begin
            if (div_if.busy === 1'b1) busy_cnt++;
            if (toggle) begin
                div_if.a = 8'($urandom_range(255));
                div_if.b = 4'($urandom_range(15));
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 20) check_val("done_timeout", {31'd0, div_if.done}, 32'd1);
        check_val("busy_with_done", {31'd0, div_if.busy}, 32'd0);
    endtask

    task automatic check_result(input string tag, input int av, input int bv);
        check_val({tag, "_Y"},   {24'd0, div_if.Y}, {24'd0, ref_y(av, bv)});
        check_val({tag, "_R"},   {28'd0, div_if.R}, {28'd0, ref_r(av, bv)});
        check_val({tag, "_dbz"}, {31'd0, div_if.div_by_zero}, (bv == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic run_div(input int av, input int bv, input bit toggle, input string tag);
        int lat, bc;
        @(negedge clk);
        div_if.start = 1'b1;
        div_if.a     = 8'(av);
        div_if.b     = 4'(bv);
        @(posedge clk);
        #1;
        div_if.start = 1'b0;
        wait_done(toggle, lat, bc);
        check_val({tag, "_lat"},  lat, (bv == 0) ? 32'd0 : 32'd8);
        check_val({tag, "_busy"}, bc,  (bv == 0) ? 32'd0 : 32'd8);
        check_result(tag, av, bv);
        @(posedge clk);
        #1;
        check_val({tag, "_done_pulse"}, {31'd0, div_if.done}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, {31'd0, div_if.busy}, 32'd0);
        check_val({tag, "_done"}, {31'd0, div_if.done}, 32'd0);
        check_val({tag, "_Y"},    {24'd0, div_if.Y}, 32'd0);
        check_val({tag, "_R"},    {28'd0, div_if.R}, 32'd0);
        check_val({tag, "_dbz"},  {31'd0, div_if.div_by_zero}, 32'd0);
    endtask

    initial begin
        int lat, bc, off, idx;
        div_if.start = 1'b0;
        div_if.a     = 8'd0;
        div_if.b     = 4'd0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_div(200, 7, 1'b0, "d200_7");
        run_div(255, 1, 1'b0, "d255_1");
        run_div(0, 5, 1'b0, "d0_5");
        run_div(14, 15, 1'b0, "d14_15");
        run_div(37, 0, 1'b0, "d37_0");
        run_div(37, 0, 1'b0, "d37_0_again");
        run_div(200, 7, 1'b1, "clear_dbz_toggle");

        // Back-to-back: start held high, new operands presented in the done cycle.
        @(negedge clk);
        div_if.start = 1'b1;
        div_if.a     = 8'd200;
        div_if.b     = 4'd7;
        @(posedge clk);
        #1;
        wait_done(1'b0, lat, bc);
        check_val("b2b_first_lat", lat, 32'd8);
        check_result("b2b_first", 200, 7);
        div_if.a = 8'd99;
        div_if.b = 4'd10;
        @(posedge clk);
        #1;
        div_if.start = 1'b0;
        check_val("b2b_no_gap_busy", {31'd0, div_if.busy}, 32'd1);
        check_val("b2b_done_once",   {31'd0, div_if.done}, 32'd0);
        wait_done(1'b1, lat, bc);
        check_val("b2b_second_lat", lat, 32'd8);
        check_result("b2b_second", 99, 10);

        // Reset in the middle of an operation.
        @(negedge clk);
        div_if.start = 1'b1;
        div_if.a     = 8'd200;
        div_if.b     = 4'd7;
        @(posedge clk);
        #1;
        div_if.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_val("midrst_no_done", {31'd0, div_if.done}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_div(200, 7, 1'b0, "after_rst");

        // Full operand sweep in a shuffled order.
        off = int'($urandom_range(4095));
        for (int i = 0; i < 4096; i++) begin
            idx = (i * 2477 + off) & 4095;
            run_div(idx & 255, (idx >> 8) & 15, ($urandom_range(1) == 1), "sweep");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
